// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - Fetch stage bus bundle: RAM instruction port, redirect, decode handshake, fault.
interface fetch_unit_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_data;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              inst_valid;
    logic [31:0]       inst;
    logic [31:0]       inst_pc;
    logic              inst_ready;
    logic              fault;
    logic [31:0]       fault_pc;

    modport master (
        output i_addr, inst_valid, inst, inst_pc, fault, fault_pc,
        input  i_data, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  i_addr, inst_valid, inst, inst_pc, fault, fault_pc,
        output i_data, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Instruction fetch: PC, one-cycle RAM read, 2-entry output FIFO, redirect and sticky fault.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 14,
    parameter int          DEPTH    = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam logic [2:0] L_DEPTH = 3'(DEPTH);

    logic [31:0] r_fetch_pc;
    logic [31:0] r_inflight_pc;
    logic        r_inflight;
    logic        r_fault;
    logic [31:0] r_fault_pc;
    logic [31:0] r_q_pc   [0:1];
    logic [31:0] r_q_inst [0:1];
    logic [1:0]  r_count;

    logic        w_aligned;
    logic        w_in_range;
    logic        w_pop;
    logic        w_redirect;
    logic        w_push;
    logic        w_issue;
    logic        w_fault_set;
    logic [2:0]  w_credit;
    logic        w_wr_idx;

    assign w_aligned   = (r_fetch_pc[1:0] == 2'b00);
    assign w_in_range  = ((r_fetch_pc >> ADDR_W) == 32'd0);
    assign w_pop       = bus.inst_valid && bus.inst_ready;
    assign w_redirect  = bus.redirect_valid && !r_fault;
    assign w_push      = r_inflight && !w_redirect;
    // Slots already promised: buffered words plus the word in flight, less the one leaving now.
    assign w_credit    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = !r_fault && !bus.redirect_valid && w_aligned && w_in_range
                         && (w_credit < L_DEPTH);
    assign w_fault_set = !r_fault && !bus.redirect_valid && !(w_aligned && w_in_range);
    assign w_wr_idx    = ((r_count - {1'b0, w_pop}) != 2'd0);

    assign bus.i_addr     = r_fetch_pc[ADDR_W-1:0];
    assign bus.inst_valid = (r_count != 2'd0);
    assign bus.inst       = r_q_inst[0];
    assign bus.inst_pc    = r_q_pc[0];
    assign bus.fault      = r_fault;
    assign bus.fault_pc   = r_fault_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'd0;
            r_fault       <= 1'b0;
            r_fault_pc    <= 32'd0;
            r_count       <= 2'd0;
            r_q_pc[0]     <= 32'd0;
            r_q_pc[1]     <= 32'd0;
            r_q_inst[0]   <= 32'd0;
            r_q_inst[1]   <= 32'd0;
        end else begin
            // Slot 0 is always the head; a pop shifts slot 1 down before any push lands.
            if (w_pop) begin
                r_q_pc[0]   <= r_q_pc[1];
                r_q_inst[0] <= r_q_inst[1];
            end
            if (w_push) begin
                r_q_pc[w_wr_idx]   <= r_inflight_pc;
                r_q_inst[w_wr_idx] <= bus.i_data;
            end

            if (w_redirect) begin
                r_count <= 2'd0;
            end else begin
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end

            if (w_redirect) begin
                r_fetch_pc <= bus.redirect_pc;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
            end

            if (w_fault_set) begin
                r_fault    <= 1'b1;
                r_fault_pc <= r_fetch_pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - Self-checking bench for fetch_unit with directed scenarios and a queue-based reference model.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    logic reset2;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(14)) bus ();
    fetch_unit_if #(.ADDR_W(14)) bus2 ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(14), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    fetch_unit #(.RESET_PC(32'h0000_3FF8), .ADDR_W(14), .DEPTH(2)) dut2 (
        .clk(clk), .reset(reset2), .bus(bus2)
    );

    logic [31:0] mem [0:4095];
    logic [31:0] seq_words [0:3];

    // One-cycle RAM: the word for the address presented this cycle appears next cycle.
    always @(posedge clk) begin
        bus.i_data  <= mem[bus.i_addr[13:2]];
        bus2.i_data <= mem[bus2.i_addr[13:2]];
    end

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc;
    logic [31:0] m_infl_pc;
    logic [31:0] m_fault_pc;
    bit          m_infl;
    bit          m_fault;
    logic [63:0] m_q[$];

    task automatic model_step();
        bit pop, ok, redir, issue, fset;
        int occ;
        if (reset) begin
            m_pc = 32'h0; m_infl = 0; m_infl_pc = 32'h0; m_q.delete();
            m_fault = 0; m_fault_pc = 32'h0;
        end else begin
            pop   = (m_q.size() != 0) && bus.inst_ready;
            ok    = (m_pc[1:0] == 2'b00) && (m_pc < 32'h4000);
            redir = bus.redirect_valid && !m_fault;
            occ   = m_q.size() + int'(m_infl) - int'(pop);
            issue = !m_fault && !bus.redirect_valid && ok && (occ < 2);
            fset  = !m_fault && !bus.redirect_valid && !ok;
            if (pop) void'(m_q.pop_front());
            if (redir) m_q.delete();
            else if (m_infl) m_q.push_back({m_infl_pc, mem[m_infl_pc[13:2]]});
            if (fset) begin m_fault = 1; m_fault_pc = m_pc; end
            if (redir) begin m_pc = bus.redirect_pc; m_infl = 0; end
            else if (issue) begin m_infl_pc = m_pc; m_pc = m_pc + 32'd4; m_infl = 1; end
            else m_infl = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.inst_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got=%h exp=0", bus.inst_valid); end
        checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", bus.inst); end
        checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got=%h exp=0", bus.inst_pc); end
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%h exp=0", bus.fault); end
        checks++; if (bus.fault_pc !== 32'h0) begin errors++; $display("FAIL reset_fault_pc got=%h exp=0", bus.fault_pc); end
        checks++; if (bus.i_addr !== 14'h0) begin errors++; $display("FAIL reset_i_addr got=%h exp=0", bus.i_addr); end
    endtask

    task automatic test_sequential();
        do_reset();
        bus.inst_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 2) begin
                checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL seq_early_valid c=%0d got=%h exp=0", c, bus.inst_valid); end
            end else begin
                checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL seq_valid c=%0d got=%h exp=1", c, bus.inst_valid); end
                checks++; if (bus.inst_pc !== 32'((c - 2) * 4)) begin errors++; $display("FAIL seq_pc c=%0d got=%h exp=%h", c, bus.inst_pc, 32'((c - 2) * 4)); end
                checks++; if (bus.inst !== seq_words[c-2]) begin errors++; $display("FAIL seq_inst c=%0d got=%h exp=%h", c, bus.inst, seq_words[c-2]); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        do_reset();
        bus.inst_ready = 1'b1;
        repeat (4) tick();
        bus.inst_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h8) begin errors++; $display("FAIL bp_hold_head c=%0d got=%h/%h exp=1/00000008", c, bus.inst_valid, bus.inst_pc); end
            checks++; if (bus.i_addr !== 14'h10) begin errors++; $display("FAIL bp_i_addr c=%0d got=%h exp=0010", c, bus.i_addr); end
            tick();
        end
        bus.inst_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            exp_pc = 32'h8 + 32'(c * 4);
            checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc) begin errors++; $display("FAIL bp_resume c=%0d got=%h/%h exp=1/%h", c, bus.inst_valid, bus.inst_pc, exp_pc); end
            checks++; if (bus.inst !== mem[exp_pc[13:2]]) begin errors++; $display("FAIL bp_inst c=%0d got=%h exp=%h", c, bus.inst, mem[exp_pc[13:2]]); end
            tick();
        end
    endtask

    task automatic test_redirect();
        logic [31:0] exp_pc;
        do_reset();
        bus.inst_ready = 1'b1;
        repeat (4) tick();
        bus.inst_ready = 1'b0;
        repeat (4) tick();
        bus.inst_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h40;
        checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL redir_head_valid got=%h exp=1", bus.inst_valid); end
        tick();
        bus.redirect_valid = 1'b0;
        for (int c = 1; c < 6; c++) begin
            if (c < 3) begin
                checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble c=%0d got=%h exp=0", c, bus.inst_valid); end
            end else begin
                exp_pc = 32'h40 + 32'((c - 3) * 4);
                checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc) begin errors++; $display("FAIL redir_target c=%0d got=%h/%h exp=1/%h", c, bus.inst_valid, bus.inst_pc, exp_pc); end
                checks++; if (bus.inst !== mem[exp_pc[13:2]]) begin errors++; $display("FAIL redir_inst c=%0d got=%h exp=%h", c, bus.inst, mem[exp_pc[13:2]]); end
            end
            tick();
        end
    endtask

    task automatic test_fault();
        do_reset();
        bus.inst_ready = 1'b1;
        repeat (3) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h42;
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL fault_early got=%h exp=0", bus.fault); end
        tick();
        checks++; if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h42) begin errors++; $display("FAIL fault_set got=%h/%h exp=1/00000042", bus.fault, bus.fault_pc); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h80;
        tick();
        bus.redirect_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL fault_no_valid c=%0d got=%h exp=0", c, bus.inst_valid); end
            checks++; if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h42) begin errors++; $display("FAIL fault_sticky c=%0d got=%h/%h exp=1/00000042", c, bus.fault, bus.fault_pc); end
            checks++; if (bus.i_addr !== 14'h42) begin errors++; $display("FAIL fault_redir_ignored c=%0d got=%h exp=0042", c, bus.i_addr); end
            tick();
        end
    endtask

    task automatic test_out_of_range();
        reset2 = 1'b1;
        tick();
        tick();
        reset2 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            case (c)
                2: begin
                    checks++; if (bus2.inst_valid !== 1'b1 || bus2.inst_pc !== 32'h3FF8) begin errors++; $display("FAIL oor_first got=%h/%h exp=1/00003ff8", bus2.inst_valid, bus2.inst_pc); end
                    checks++; if (bus2.inst !== mem[12'hFFE]) begin errors++; $display("FAIL oor_first_inst got=%h exp=%h", bus2.inst, mem[12'hFFE]); end
                    checks++; if (bus2.fault !== 1'b0) begin errors++; $display("FAIL oor_fault_early got=%h exp=0", bus2.fault); end
                end
                3: begin
                    checks++; if (bus2.inst_valid !== 1'b1 || bus2.inst_pc !== 32'h3FFC) begin errors++; $display("FAIL oor_second got=%h/%h exp=1/00003ffc", bus2.inst_valid, bus2.inst_pc); end
                    checks++; if (bus2.fault !== 1'b1 || bus2.fault_pc !== 32'h4000) begin errors++; $display("FAIL oor_fault got=%h/%h exp=1/00004000", bus2.fault, bus2.fault_pc); end
                end
                default: begin
                    checks++; if (bus2.inst_valid !== 1'b0) begin errors++; $display("FAIL oor_idle c=%0d got=%h exp=0", c, bus2.inst_valid); end
                end
            endcase
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h3FF8;
        tick();
        bus.redirect_valid = 1'b0;
        repeat (4) tick();
        checks++; if (bus.fault !== 1'b1 || bus.inst_valid !== 1'b1) begin errors++; $display("FAIL mid_precond got=%h/%h exp=1/1", bus.fault, bus.inst_valid); end
        reset = 1'b1;
        tick();
        checks++; if (bus.inst_valid !== 1'b0 || bus.fault !== 1'b0) begin errors++; $display("FAIL mid_cleared got=%h/%h exp=0/0", bus.inst_valid, bus.fault); end
        checks++; if (bus.i_addr !== 14'h0) begin errors++; $display("FAIL mid_i_addr got=%h exp=0000", bus.i_addr); end
        reset = 1'b0;
        bus.inst_ready = 1'b1;
        tick();
        tick();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin errors++; $display("FAIL mid_restart got=%h/%h exp=1/00000000", bus.inst_valid, bus.inst_pc); end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            bus.inst_ready = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 11) == 0);
            r = $urandom_range(0, 39);
            if (r == 0) bus.redirect_pc = {18'h0, 12'($urandom), 2'b10};
            else if (r == 1) bus.redirect_pc = 32'h4000 + {18'h0, 12'($urandom), 2'b00};
            else bus.redirect_pc = {18'h0, 12'($urandom), 2'b00};
            checks++; if (bus.inst_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid c=%0d got=%h exp=%h", c, bus.inst_valid, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                checks++; if ({bus.inst_pc, bus.inst} !== m_q[0]) begin errors++; $display("FAIL rnd_head c=%0d got=%h exp=%h", c, {bus.inst_pc, bus.inst}, m_q[0]); end
            end
            checks++; if (bus.fault !== m_fault || bus.fault_pc !== m_fault_pc) begin errors++; $display("FAIL rnd_fault c=%0d got=%h/%h exp=%h/%h", c, bus.fault, bus.fault_pc, m_fault, m_fault_pc); end
            checks++; if (bus.i_addr !== m_pc[13:0]) begin errors++; $display("FAIL rnd_i_addr c=%0d got=%h exp=%h", c, bus.i_addr, m_pc[13:0]); end
            tick();
        end
        reset = 1'b0;
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        seq_words[0] = 32'h0000_0013;
        seq_words[1] = 32'h0010_0093;
        seq_words[2] = 32'h0020_0113;
        seq_words[3] = 32'h0030_0193;
        for (int i = 0; i < 4; i++) mem[i] = seq_words[i];
        reset = 1'b1;
        reset2 = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready = 1'b0;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc = 32'h0;
        bus2.inst_ready = 1'b1;

        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_fault();
        test_out_of_range();
        test_reset_midstream();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
